// File: rtl/mult_accum_stage_if.sv
// Handshake bundle for the accumulate stage: product beat stream in, frame result out.
// The stage connects through the slave modport and its driver through the master modport.
interface mult_accum_stage_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/mult_accum_stage.sv
// Accumulates a frame of signed products into a sign-extended running sum and
// presents sum, beat count and sticky overflow on a valid/ready result port.
module mult_accum_stage #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  mult_accum_stage_if.slave   bus
);

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  state_t            state, state_next;
  logic [ACC_W-1:0]  acc_q, sum_q;
  logic [CNT_W-1:0]  cnt_q, count_q;
  logic              ovf_q, overflow_q;

  logic              accept;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  acc_next;
  logic [CNT_W-1:0]  cnt_next;
  logic              ovf_next;

  assign accept   = bus.in_valid && (state == ST_ACC);
  assign prod_ext = {{(ACC_W-PROD_W){bus.in_product[PROD_W-1]}}, bus.in_product};
  assign acc_next = acc_q + prod_ext;
  assign cnt_next = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  // Signed overflow: addends agree in sign but the wrapped result does not.
  assign ovf_next = ovf_q ||
                    ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (acc_next[ACC_W-1] != acc_q[ACC_W-1]));

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    bus.in_ready  = (state == ST_ACC);
    bus.out_valid = (state == ST_DONE);
    if (clear) begin
      state_next = ST_ACC;
    end else begin
      case (state)
        ST_ACC:  if (accept && bus.in_last) state_next = ST_DONE;
        ST_DONE: if (bus.out_ready)         state_next = ST_ACC;
        default: state_next = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      if (bus.in_last) begin
        // Result registers capture the post-update frame totals; the running
        // state restarts from zero for the next frame.
        sum_q      <= acc_next;
        count_q    <= cnt_next;
        overflow_q <= ovf_next;
        acc_q      <= '0;
        cnt_q      <= '0;
        ovf_q      <= 1'b0;
      end else begin
        acc_q      <= acc_next;
        cnt_q      <= cnt_next;
        ovf_q      <= ovf_next;
      end
    end
  end

  assign bus.out_sum      = sum_q;
  assign bus.out_count    = count_q;
  assign bus.out_overflow = overflow_q;

endmodule

// File: tb/tb_mult_accum_stage.sv
// Directed and randomized frames for mult_accum_stage, checked against an
// integer-arithmetic frame model.
module tb_mult_accum_stage;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  mult_accum_stage_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  mult_accum_stage #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame model: exact signed sum kept inside the 16-bit range, overflow
  // whenever an exact addition leaves that range.
  int mdl_acc, mdl_cnt;
  bit mdl_ovf;
  int exp_sum, exp_cnt;
  bit exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    mdl_acc = 0;
    mdl_cnt = 0;
    mdl_ovf = 0;
  endtask

  task automatic mdl_beat(input logic [7:0] p, input bit last);
    int pv;
    int t;
    pv = $signed(p);
    t  = mdl_acc + pv;
    if (t > 32767) begin
      mdl_ovf = 1;
      t -= 65536;
    end else if (t < -32768) begin
      mdl_ovf = 1;
      t += 65536;
    end
    mdl_acc = t;
    if (mdl_cnt < 255) mdl_cnt++;
    if (last) begin
      exp_sum = mdl_acc & 16'hFFFF;
      exp_cnt = mdl_cnt;
      exp_ovf = mdl_ovf;
      mdl_clear();
    end
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_ready"}, bus.in_ready, 0);
    check({tag, "_sum"},   bus.out_sum, exp_sum);
    check({tag, "_count"}, bus.out_count, exp_cnt);
    check({tag, "_ovf"},   bus.out_overflow, exp_ovf);
  endtask

  // Presents one beat, waits (bounded) for in_ready, and returns how many
  // cycles it had to wait. Called at #1 after a rising edge.
  task automatic send_beat(input logic [7:0] p, input bit last, input string tag, output int waits);
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    bus.in_last    = last;
    waits = 0;
    while (!bus.in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 50) check({tag, "_ready_timeout"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    mdl_beat(p, last);
    if (last) check_result(tag);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop"}, bus.out_valid, 0);
    check({tag, "_rdy"},  bus.in_ready, 1);
  endtask

  task automatic send_frame(input int len, input logic [7:0] p_fixed, input bit rnd, input string tag);
    int w;
    logic [7:0] p;
    for (int i = 0; i < len; i++) begin
      p = rnd ? 8'($urandom) : p_fixed;
      send_beat(p, i == len - 1, tag, w);
      if (i != len - 1 && i < 3) check({tag, "_midframe_valid"}, bus.out_valid, 0);
    end
  endtask

  initial begin
    int w;
    logic [15:0] held_sum;

    rst_n          = 1'b0;
    clear          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    mdl_clear();

    // Reset values
    #12;
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum",   bus.out_sum, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_out_ovf",   bus.out_overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame: 05, FD, 10 -> 0x0012, count 3
    send_beat(8'h05, 0, "basic", w);
    send_beat(8'hFD, 0, "basic", w);
    check("basic_no_early_valid", bus.out_valid, 0);
    send_beat(8'h10, 1, "basic", w);
    check("basic_sum_const", bus.out_sum, 16'h0012);
    release_result("basic");

    // Single-beat frame followed back-to-back by another, out_ready held high
    bus.out_ready = 1'b1;
    send_beat(8'hF8, 1, "single", w);
    check("single_sum_const", bus.out_sum, 16'hFFF8);
    send_beat(8'h21, 0, "b2b", w);
    check("b2b_bubble", w, 1);
    bus.out_ready = 1'b0;
    send_beat(8'hE0, 1, "b2b", w);
    release_result("b2b");

    // Overflow boundary: 258 beats stay in range, 259 wrap and saturate count
    send_frame(258, 8'h7F, 0, "ovf258");
    check("ovf258_sum_const", bus.out_sum, 16'h7FFE);
    release_result("ovf258");
    send_frame(259, 8'h7F, 0, "ovf259");
    check("ovf259_sum_const", bus.out_sum, 16'h807D);
    check("ovf259_cnt_const", bus.out_count, 8'hFF);
    check("ovf259_ovf_const", bus.out_overflow, 1);

    // Back-pressure with a beat waiting
    held_sum       = bus.out_sum;
    bus.in_valid   = 1'b1;
    bus.in_product = 8'h9C;
    bus.in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready",  bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_sum_hold",  bus.out_sum, held_sum);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    mdl_beat(8'h9C, 1);
    check_result("bp_pending");
    release_result("bp_pending");

    // Random frames with random output stalls
    for (int f = 0; f < 8; f++) begin
      int stall;
      send_frame($urandom_range(1, 6), 8'h00, 1, "rnd");
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check("rnd_stall_valid", bus.out_valid, 1);
        check("rnd_stall_sum",   bus.out_sum, exp_sum);
      end
      release_result("rnd");
    end

    // clear mid-frame discards the partial sum and a same-cycle beat
    send_beat(8'h11, 0, "clr", w);
    send_beat(8'h22, 0, "clr", w);
    clear          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_product = 8'h40;
    bus.in_last    = 1'b1;
    @(posedge clk); #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    mdl_clear();
    check("clr_no_valid", bus.out_valid, 0);
    check("clr_ready",    bus.in_ready, 1);
    send_beat(8'h01, 1, "clr_after", w);
    check("clr_after_sum_const", bus.out_sum, 1);
    check("clr_after_cnt_const", bus.out_count, 1);

    // clear while DONE zeroes the result
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_done_valid", bus.out_valid, 0);
    check("clr_done_sum",   bus.out_sum, 0);
    check("clr_done_count", bus.out_count, 0);

    // Asynchronous reset while DONE, between clock edges
    send_beat(8'h33, 0, "arst", w);
    send_beat(8'h44, 1, "arst", w);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_sum",   bus.out_sum, 0);
    check("arst_count", bus.out_count, 0);
    check("arst_ready", bus.in_ready, 1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_post_ready", bus.in_ready, 1);
    send_beat(8'h80, 1, "arst_next", w);
    release_result("arst_next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
